async_fifo: RTL and testbench

ASYNC_FIFO -- requirements
Module: async_fifo

---
 rtl/async_fifo_pkg.sv | 6 +
 rtl/fifo_mem.sv | 33 +++
 rtl/async_fifo.sv | 59 +++++
 tb/tb_async_fifo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared FIFO sizing constants
package async_fifo_pkg;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int FIFO_DEPTH         = 1 << DEFAULT_ADDR_WIDTH;
endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - dual-port storage array with synchronous write and registered read
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // The array itself is never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - single-clock FIFO: pointer and flag logic around fifo_mem
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fifo_full,
    output logic                  fifo_empty
);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic                wr_ok;
    logic                rd_ok;

    // The extra MSB distinguishes full from empty when the address bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                        (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    assign wr_ok = wr_en && !fifo_full;
    assign rd_ok = rd_en && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - scoreboard bench for async_fifo against a queue reference model
module tb_async_fifo;
    import async_fifo_pkg::*;

    localparam int DW    = DEFAULT_DATA_WIDTH;
    localparam int DEPTH = FIFO_DEPTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          fifo_full;
    logic          fifo_empty;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];

    async_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // One clock of stimulus; the reference model decides acceptance from occupancy alone.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        int n;
        @(negedge clk);
        rst_n   = 1'b1;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        n = model_q.size();
        if (r && n > 0) exp_q.push_back(model_q.pop_front());
        if (w && n < DEPTH) model_q.push_back(d);
        @(posedge clk);
        #1;
        tests++;
        if (fifo_full !== (model_q.size() == DEPTH)) begin
            fails++;
            $display("FAIL full_flag: got %b expected %b (count %0d)", fifo_full, model_q.size() == DEPTH, model_q.size());
        end
        tests++;
        if (fifo_empty !== (model_q.size() == 0)) begin
            fails++;
            $display("FAIL empty_flag: got %b expected %b (count %0d)", fifo_empty, model_q.size() == 0, model_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || rd_data !== '0) begin
            fails++;
            $display("FAIL %s: empty=%b full=%b rd_data=%h expected empty=1 full=0 rd_data=00",
                     name, fifo_empty, fifo_full, rd_data);
        end
    endtask

    // Monitor: a read is taken on an edge where rd_en is high and the FIFO is not empty.
    initial begin
        logic          took;
        logic          in_rst;
        logic [DW-1:0] last_exp;
        logic [DW-1:0] e;
        last_exp = '0;
        forever begin
            @(negedge clk);
            #2;
            took   = rst_n && rd_en && !fifo_empty;
            in_rst = !rst_n;
            @(posedge clk);
            #1;
            if (in_rst || !rst_n) begin
                exp_q.delete();
                last_exp = '0;
            end else if (took) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read: got %h expected no read", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    if (rd_data !== e) begin
                        fails++;
                        $display("FAIL rd_data: got %h expected %h", rd_data, e);
                    end
                end
            end else begin
                tests++;
                if (rd_data !== last_exp) begin
                    fails++;
                    $display("FAIL rd_hold: got %h expected %h", rd_data, last_exp);
                end
            end
        end
    end

    initial begin
        #13;
        check_reset_outputs("reset_state");
        @(posedge clk);

        for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        for (int i = 0; i < 10; i++) step(1'b1, DW'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, DW'(8'h20 + i), 1'b0);
        step(1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 8'h66, 1'b1);
        step(1'b1, 8'h67, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        check_reset_outputs("reset_mid_op");
        @(posedge clk);
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 75 : 30;
            step($urandom_range(99) < wp, DW'($urandom), $urandom_range(99) < (100 - wp));
        end
        while (model_q.size() > 0) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected reads never observed, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
